// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 opcodes,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // Most negative signed value; also the architected DIV overflow quotient.
  localparam logic [XLEN_DEFAULT-1:0] DIV_OVF_RESULT = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: LSB-first shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
import muldiv_pkg::*;

module muldiv_step #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              bit_in,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] rem_new;
  logic            q_bit;

  // NOTE: every variable gets a value on every path through always_comb;
  // a missing assignment on any branch would infer a latch.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (bit_in ? {1'b0, operand} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], bit_in};
    q_bit    = (rem_sh >= {1'b0, operand});
    // When the subtract succeeds the true difference is below the divisor,
    // so the truncated XLEN-bit difference is exact.
    rem_sub  = rem_sh[XLEN-1:0] - operand;
    rem_new  = q_bit ? rem_sub : rem_sh[XLEN-1:0];
    if (is_div) begin
      acc_next = {rem_new, acc[XLEN-2:0], q_bit};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (IDLE -> CALC -> FIXUP -> DONE).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            Clk_Core,
  input  logic            Rst_Core,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Operand_A,
  input  logic [XLEN-1:0] Operand_B,
  input  logic [4:0]      Rd_Addr_In,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      Rd_Addr_Out
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              neg_lo;
  logic              neg_hi;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;

  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;

  // Operand conditioning for the request presented on this cycle.
  always_comb begin
    a_signed = (Funct3 == FUNCT3_MULH) || (Funct3 == FUNCT3_MULHSU) ||
               (Funct3 == FUNCT3_DIV)  || (Funct3 == FUNCT3_REM);
    b_signed = (Funct3 == FUNCT3_MULH) || (Funct3 == FUNCT3_DIV) || (Funct3 == FUNCT3_REM);
    sign_a   = a_signed && Operand_A[XLEN-1];
    sign_b   = b_signed && Operand_B[XLEN-1];
    abs_a    = sign_a ? -Operand_A : Operand_A;
    abs_b    = sign_b ? -Operand_B : Operand_B;
    div_zero = Funct3[2] && (Operand_B == '0);
    div_ovf  = ((Funct3 == FUNCT3_DIV) || (Funct3 == FUNCT3_REM)) &&
               (Operand_A == XLEN'(DIV_OVF_RESULT)) && (Operand_B == '1);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op[2]),
    .acc      (acc),
    .operand  (op[2] ? opb : opa),
    .bit_in   (op[2] ? opa[XLEN-1] : opb[0]),
    .acc_next (acc_step)
  );

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  // Sign fix-up: neg_lo covers the product and the quotient, neg_hi the remainder.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quot_fix = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      FUNCT3_MUL:                              fix_result = prod_fix[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                 fix_result = quot_fix;
      default:                                 fix_result = rem_fix;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op          <= '0;
      rd_q        <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Result      <= '0;
      Rd_Addr_Out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            op     <= Funct3;
            rd_q   <= Rd_Addr_In;
            opa    <= abs_a;
            opb    <= abs_b;
            neg_lo <= sign_a ^ sign_b;
            neg_hi <= sign_a;
            acc    <= '0;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= ST_CALC;
            // Special cases preload the final quotient/remainder and bypass CALC.
            if (div_zero) begin
              acc    <= {Operand_A, {XLEN{1'b1}}};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              state  <= ST_FIXUP;
            end else if (div_ovf) begin
              acc    <= {{XLEN{1'b0}}, XLEN'(DIV_OVF_RESULT)};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              state  <= ST_FIXUP;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!Funct3[2]) begin
              acc   <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
              state <= ST_FIXUP;
            end
`endif
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          if (op[2]) begin
            opa <= {opa[XLEN-2:0], 1'b0};
          end else begin
            opb <= {1'b0, opb[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          Result      <= fix_result;
          Rd_Addr_Out <= rd_q;
          Done        <= 1'b1;
          state       <= ST_DONE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// special cases, ignored Start while busy and mid-operation reset.
import muldiv_pkg::*;

module tb_muldiv_unit;

  logic        Clk_Core = 1'b0;
  logic        Rst_Core = 1'b1;
  logic        Start    = 1'b0;
  logic [2:0]  Funct3   = '0;
  logic [31:0] Operand_A = '0;
  logic [31:0] Operand_B = '0;
  logic [4:0]  Rd_Addr_In = '0;
  logic        Busy, Done;
  logic [31:0] Result;
  logic [4:0]  Rd_Addr_Out;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  muldiv_unit dut (
    .Clk_Core    (Clk_Core),
    .Rst_Core    (Rst_Core),
    .Start       (Start),
    .Funct3      (Funct3),
    .Operand_A   (Operand_A),
    .Operand_B   (Operand_B),
    .Rd_Addr_In  (Rd_Addr_In),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .Rd_Addr_Out (Rd_Addr_Out)
  );

  always #5 Clk_Core = ~Clk_Core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency = number of edges after the Start-sampling edge up to the edge that raises Done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat = 0;
    @(negedge Clk_Core);
    Funct3 = f; Operand_A = a; Operand_B = b; Rd_Addr_In = rd; Start = 1'b1;
    @(posedge Clk_Core); #1;
    Start = 1'b0;
    while (!Done && lat < 100) begin
      @(posedge Clk_Core); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, Result, exp_res);
    check({tag, "_rd"}, {27'd0, Rd_Addr_Out}, {27'd0, rd});
    check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    @(posedge Clk_Core); #1;
    check({tag, "_pulse"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int done_lat;
    logic [4:0]  done_rd;
    logic [31:0] done_res;

    // Reset state
    repeat (3) @(posedge Clk_Core);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_res", Result, 32'd0);
    check("rst_rd", {27'd0, Rd_Addr_Out}, 32'd0);
    @(negedge Clk_Core);
    Rst_Core = 1'b0;

    // Multiplies
    run_op("mul",      FUNCT3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",     FUNCT3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, MUL_LAT);
    run_op("mulhsu",   FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu",    FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_neg", FUNCT3_MULH,   32'h8000_0000, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu_p", FUNCT3_MULHSU, 32'h0000_0002, 32'h8000_0000, 5'd10, 32'h0000_0001, MUL_LAT);

    // Divides
    run_op("div",      FUNCT3_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",      FUNCT3_REM,  32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",     FUNCT3_DIVU, 32'd100,       32'd7,         5'd13, 32'd14,        DIV_LAT);
    run_op("remu",     FUNCT3_REMU, 32'd100,       32'd7,         5'd0,  32'd2,         DIV_LAT);
    run_op("div_nb",   FUNCT3_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_nb",   FUNCT3_REM,  32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'h0000_0001, DIV_LAT);

    // Special cases
    run_op("div_z",    FUNCT3_DIV,  32'h0000_1234, 32'h0, 5'd16, 32'hFFFF_FFFF, SPC_LAT);
    run_op("rem_z",    FUNCT3_REM,  32'h0000_1234, 32'h0, 5'd17, 32'h0000_1234, SPC_LAT);
    run_op("divu_z",   FUNCT3_DIVU, 32'hFFFF_0000, 32'h0, 5'd18, 32'hFFFF_FFFF, SPC_LAT);
    run_op("remu_z",   FUNCT3_REMU, 32'hFFFF_0000, 32'h0, 5'd19, 32'hFFFF_0000, SPC_LAT);
    run_op("div_ovf",  FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, SPC_LAT);
    run_op("rem_ovf",  FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0000_0000, SPC_LAT);

    // Start pulses at cycles 5 and 10 of a busy divide must be ignored
    @(negedge Clk_Core);
    Funct3 = FUNCT3_DIVU; Operand_A = 32'd100; Operand_B = 32'd7; Rd_Addr_In = 5'd9; Start = 1'b1;
    @(posedge Clk_Core); #1;
    Start = 1'b0;
    n_done = 0; done_lat = 0; done_rd = '0; done_res = '0;
    for (cyc = 1; cyc <= 45; cyc++) begin
      @(posedge Clk_Core); #1;
      if (Done) begin
        n_done++;
        if (n_done == 1) begin
          done_lat = cyc; done_rd = Rd_Addr_Out; done_res = Result;
        end
      end
      if (cyc == 4 || cyc == 9) begin
        Start = 1'b1; Funct3 = FUNCT3_DIV; Operand_A = 32'd50; Operand_B = 32'd5; Rd_Addr_In = 5'd3;
      end else begin
        Start = 1'b0;
      end
    end
    check("ign_ndone", 32'(n_done), 32'd1);
    check("ign_lat", 32'(done_lat), 32'(DIV_LAT));
    check("ign_rd", {27'd0, done_rd}, 32'd9);
    check("ign_res", done_res, 32'd14);

    // Reset at cycle 12 of a DIVU abandons it
    @(negedge Clk_Core);
    Funct3 = FUNCT3_DIVU; Operand_A = 32'd100; Operand_B = 32'd7; Rd_Addr_In = 5'd22; Start = 1'b1;
    @(posedge Clk_Core); #1;
    Start = 1'b0;
    repeat (11) begin
      @(posedge Clk_Core); #1;
    end
    Rst_Core = 1'b1;
    @(posedge Clk_Core); #1;
    Rst_Core = 1'b0;
    check("mrst_busy", {31'd0, Busy}, 32'd0);
    check("mrst_done", {31'd0, Done}, 32'd0);
    check("mrst_res", Result, 32'd0);
    n_done = 0;
    repeat (40) begin
      @(posedge Clk_Core); #1;
      if (Done) n_done++;
    end
    check("mrst_nodone", 32'(n_done), 32'd0);
    run_op("post_rst", FUNCT3_REMU, 32'd100, 32'd7, 5'd23, 32'd2, DIV_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
